imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written through the memory's write port at consecutive word-aligned byte addresses starting at 0x0. The processor core is held in reset until a complete, checksum-verified image has been written. The block sits between the host byte link and the instruction memory write port; it is the write-side counterpart of the core's combinational fetch read (`pc_i` to `instr_o`).

## Interface
- `ADDR_W`, default 13: word-address width of the target memory. Capacity is 2**ADDR_W words (8192 by default).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: single-cycle pulse that begins a load session. Honoured only in IDLE, DONE or ERR.
- `byte_valid_i` in 1: a stream byte is present.
- `byte_data_i` in 8: stream byte.
- `byte_ready_o` out 1: loader accepts a byte this cycle.
- `wr_en_o` out 1: instruction memory write strobe, one cycle per word.
- `wr_addr_o` out 32: byte address of the write, always word-aligned (`idx << 2`).
- `wr_data_o` out 32: instruction word.
- `core_rst_o` out 1: core reset request, held high until DONE.
- `busy_o` out 1: a session is in progress (LEN, DATA, WRITE or CHK).
- `done_o` out 1: image loaded and verified.
- `err_o` out 1: session aborted.

## Operation
- **Byte transfer rule.** A byte transfers on a rising edge where `byte_valid_i && byte_ready_o`. `byte_ready_o` is high only in LEN, DATA and CHK.
- **Stream format:**
  - 4 bytes word count N, LSB first;
  - N×4 data bytes, each word LSB first;
  - 1 checksum byte equal to the XOR of all N×4 data bytes.
- **States:**
  - **IDLE:** on `start_i`, go to LEN. Clear byte counter, word index `idx` and checksum accumulator.
  - **LEN:** shift in 4 bytes. After the 4th byte:
    - N==0 → DONE;
    - N > 2**ADDR_W → ERR;
    - otherwise → DATA.
  - **DATA:** shift bytes into the word register at lane `byte_cnt`, and XOR each byte into the accumulator. The 4th byte → WRITE.
  - **WRITE:** exactly one cycle.
    - `wr_en_o`=1, `wr_addr_o`=`idx<<2`, `wr_data_o`=assembled word.
    - `idx` increments.
    - If `idx+1`==N → CHK, else → DATA.
  - **CHK:** accept 1 byte. If it equals the accumulator → DONE, else → ERR.
  - **DONE:** `done_o`=1, `core_rst_o`=0. `start_i` → LEN (reload). On reload, `core_rst_o` returns to 1 and `done_o` clears.
  - **ERR:** `err_o`=1, `core_rst_o`=1. `start_i` → LEN.
- **Arithmetic.** N is held in 32 bits. The comparison against 2**ADDR_W is done in 33-bit arithmetic, so no wrap. `idx` is ADDR_W+1 bits wide, so idx = 2**ADDR_W − 1 is the last word and there is no wrap-around. `wr_addr_o` bits above ADDR_W+1 are zero.
- **`start_i` outside IDLE/DONE/ERR** is ignored.
- **`byte_valid_i` stalls** (gaps of any length) only delay progress. State and partial words are retained.
- **Reset mid-session:** all registers return to reset values immediately. Words already written remain in memory. The next session is clean.
- **Reset values:** `byte_ready_o`=0, `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `core_rst_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, state IDLE.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- `start_i` sampled at edge k → LEN, with `byte_ready_o`=1 after edge k.
- **Word write timing.** The 4th data byte is accepted at edge k. `wr_en_o` is high between edges k and k+1. `byte_ready_o` is low in that cycle. DATA resumes after edge k+1.
- Peak throughput: one word per 5 cycles.
- `core_rst_o` falls and `done_o` rises on the same edge that enters DONE. `err_o` rises on the edge entering ERR.
- **Error latency.** For an oversize N, ERR is entered on the edge after the 4th length byte is accepted, and no write ever occurs.
- `wr_addr_o` and `wr_data_o` hold their last values outside WRITE. Only `wr_en_o` qualifies them.

## Test plan
- **Nominal load.** Send N=9, then words 0x00c00093, 0x00e00193, 0x00a00293, 0x55555337, 0x40118133, 0x00517633, 0x002366b3, 0x00210733, 0x002007b3, then the correct XOR.
  - Required: 9 single-cycle writes at 0x00, 0x04 … 0x20 with matching data.
  - Then `done_o`=1 and `core_rst_o`=0.
- **Bad checksum.** Same image with checksum ^ 0x01.
  - Required: all 9 writes occur.
  - Then `err_o`=1, `core_rst_o` stays 1 and `done_o`=0.
- **Length limits.** With ADDR_W=13:
  - N=8193 → ERR after the 4th length byte, zero writes.
  - N=0 → DONE after 4 bytes, zero writes.
- **Back-pressure and gaps.** Nominal image with `byte_valid_i` toggled randomly, including gaps of 0–7 cycles.
  - Required: write sequence identical to the nominal load.
  - No byte is accepted while `byte_ready_o`=0.
- **Reset mid-load.** Assert `rst_i` asynchronously between clock edges after the 3rd write.
  - Required: outputs return to reset values immediately.
  - A new `start_i` plus the full image then completes with 9 writes and `done_o`=1.
- **Reload from DONE.** `start_i` in DONE.
  - Required: `core_rst_o` rises and `done_o` clears on the next edge.
  - A second image of N=2 writes to 0x00 and 0x04, then ends in DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed, checksummed
// little-endian byte stream into 32-bit words and releases the core once verified.
module imem_loader #(
  parameter int ADDR_W = 13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o;
  // the host holds byte_data_i stable while byte_valid_i is high and ready is low.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q;
  logic [31:0]     n_q;
  logic [ADDR_W:0] idx_q;
  logic [7:0]      csum_q;
  logic [23:0]     word_q;
  logic [31:0]     wr_addr_q;
  logic [31:0]     wr_data_q;

  logic            accept;
  logic            start_ok;
  logic [31:0]     n_full;
  logic            n_too_big;
  logic [ADDR_W:0] idx_inc;
  logic            last_word;

  assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign wr_en_o      = (state_q == S_WRITE);
  assign busy_o       = byte_ready_o || wr_en_o;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);
  assign core_rst_o   = (state_q != S_DONE);
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign dbg_state_o  = state_q;

  assign accept    = byte_valid_i && byte_ready_o;
  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign n_full    = {byte_data_i, n_q[31:8]};
  // 33-bit compare so a count near 2**32 cannot wrap below the capacity.
  assign n_too_big = {1'b0, n_full} > (33'd1 << ADDR_W);
  assign idx_inc   = idx_q + 1'b1;
  assign last_word = (32'(idx_inc) == n_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_LEN;
      S_LEN: begin
        if (accept && byte_cnt_q == 2'd3) begin
          if (n_full == 32'd0) state_d = S_DONE;
          else if (n_too_big)  state_d = S_ERR;
          else                 state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CHK : S_DATA;
      S_CHK:   if (accept) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else if (start_ok) begin
      byte_cnt_q <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
    end else begin
      if (accept && state_q == S_LEN) begin
        n_q        <= n_full;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (accept && state_q == S_DATA) begin
        csum_q     <= csum_q ^ byte_data_i;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0: word_q[7:0]   <= byte_data_i;
          2'd1: word_q[15:8]  <= byte_data_i;
          2'd2: word_q[23:16] <= byte_data_i;
          default: begin
            // Top lane goes straight to the write register so WRITE follows immediately.
            wr_data_q <= {byte_data_i, word_q};
            wr_addr_q <= 32'({idx_q, 2'b00});
          end
        endcase
      end
      if (state_q == S_WRITE) idx_q <= idx_inc;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal image, bad checksum, length limits,
// stalled stream, mid-load reset and reload from DONE.
module tb_imem_loader;
  localparam int ADDR_W = 13;

  logic        clk = 1'b0;
  logic        rst_i, start_i, byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o, wr_en_o, core_rst_o, busy_o, done_o, err_o;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int accepted = 0;
  logic prev_wr = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] img [0:8];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe pops one expected {addr, data}
  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_count++;
      check("wr_expected_present", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("wr_addr_data", {wr_addr_o, wr_data_o}, exp_q.pop_front());
      check("ready_low_in_write", 64'(byte_ready_o), 64'd0);
      check("wr_single_cycle", 64'(prev_wr), 64'd0);
    end
    prev_wr = wr_en_o;
  end

  // drivers (entered and left at a falling edge)
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    int waited = 0;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready_o) begin
      checks++;
      errors++;
      $error("FAIL byte_timeout observed=ready_low expected=ready_high");
      byte_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    accepted++;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic push_exp(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({32'(i * 4), img[i]});
  endtask

  task automatic send_image(input int count, input logic [7:0] chk, input int max_gap);
    send_word(32'(count), max_gap);
    for (int i = 0; i < count; i++) send_word(img[i], max_gap);
    send_byte(chk, max_gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   64'(byte_ready_o), 64'd0);
    check({tag, "_wr_en"},   64'(wr_en_o),      64'd0);
    check({tag, "_addr"},    64'(wr_addr_o),    64'd0);
    check({tag, "_data"},    64'(wr_data_o),    64'd0);
    check({tag, "_core_rst"},64'(core_rst_o),   64'd1);
    check({tag, "_busy"},    64'(busy_o),       64'd0);
    check({tag, "_done"},    64'(done_o),       64'd0);
    check({tag, "_err"},     64'(err_o),        64'd0);
    check({tag, "_state"},   64'(dbg_state_o),  64'd0);
  endtask

  initial begin
    img[0] = 32'h00c00093; img[1] = 32'h00e00193; img[2] = 32'h00a00293;
    img[3] = 32'h55555337; img[4] = 32'h40118133; img[5] = 32'h00517633;
    img[6] = 32'h002366b3; img[7] = 32'h00210733; img[8] = 32'h002007b3;
    rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    #3;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // nominal load, XOR of all data bytes is 0xf4
    start_pulse();
    check("start_busy", 64'(busy_o), 64'd1);
    check("start_ready", 64'(byte_ready_o), 64'd1);
    wr_count = 0;
    push_exp(9);
    send_image(9, 8'hf4, 0);
    check("nom_done", 64'(done_o), 64'd1);
    check("nom_core_rst", 64'(core_rst_o), 64'd0);
    check("nom_err", 64'(err_o), 64'd0);
    check("nom_busy", 64'(busy_o), 64'd0);
    check("nom_writes", 64'(wr_count), 64'd9);

    // bad checksum, started from DONE
    start_pulse();
    check("bad_core_rst_on_start", 64'(core_rst_o), 64'd1);
    wr_count = 0;
    push_exp(9);
    send_image(9, 8'hf5, 0);
    check("bad_err", 64'(err_o), 64'd1);
    check("bad_core_rst", 64'(core_rst_o), 64'd1);
    check("bad_done", 64'(done_o), 64'd0);
    check("bad_writes", 64'(wr_count), 64'd9);

    // N = 8193 exceeds capacity
    start_pulse();
    check("over_err_cleared", 64'(err_o), 64'd0);
    wr_count = 0;
    send_word(32'd8193, 0);
    for (int i = 0; i < 2 && !err_o; i++) @(negedge clk);
    check("over_err", 64'(err_o), 64'd1);
    check("over_done", 64'(done_o), 64'd0);
    check("over_busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    check("over_writes", 64'(wr_count), 64'd0);

    // N = 8192 is exactly capacity and must be accepted
    start_pulse();
    send_word(32'd8192, 0);
    check("cap_busy", 64'(busy_o), 64'd1);
    check("cap_err", 64'(err_o), 64'd0);
    check("cap_ready", 64'(byte_ready_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // N = 0 completes straight after the length
    start_pulse();
    wr_count = 0;
    send_word(32'd0, 0);
    check("zero_done", 64'(done_o), 64'd1);
    check("zero_core_rst", 64'(core_rst_o), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_writes", 64'(wr_count), 64'd0);

    // stalled stream with random gaps
    start_pulse();
    wr_count = 0;
    accepted = 0;
    push_exp(9);
    send_image(9, 8'hf4, 7);
    check("bp_done", 64'(done_o), 64'd1);
    check("bp_writes", 64'(wr_count), 64'd9);
    check("bp_bytes", 64'(accepted), 64'd41);
    check("bp_exp_empty", 64'(exp_q.size()), 64'd0);

    // reset between edges during the third write
    start_pulse();
    wr_count = 0;
    push_exp(3);
    send_word(32'd9, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], 0);
    #2;
    check("rst_mid_writes", 64'(wr_count), 64'd3);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_exp_empty", 64'(exp_q.size()), 64'd0);
    start_pulse();
    wr_count = 0;
    push_exp(9);
    send_image(9, 8'hf4, 0);
    check("rst_reload_done", 64'(done_o), 64'd1);
    check("rst_reload_writes", 64'(wr_count), 64'd9);

    // reload from DONE with a 2-word image; 11223344 ^ a5a5a5a5 bytes XOR to 0x44
    start_pulse();
    check("reload_core_rst", 64'(core_rst_o), 64'd1);
    check("reload_done", 64'(done_o), 64'd0);
    img[0] = 32'h11223344;
    img[1] = 32'ha5a5a5a5;
    wr_count = 0;
    push_exp(2);
    send_word(32'd2, 0);
    start_pulse();
    check("start_ignored_busy", 64'(dbg_state_o), 64'd2);
    send_word(img[0], 0);
    send_word(img[1], 0);
    send_byte(8'h44, 0);
    check("reload2_done", 64'(done_o), 64'd1);
    check("reload2_core_rst", 64'(core_rst_o), 64'd0);
    check("reload2_writes", 64'(wr_count), 64'd2);
    check("reload2_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
